// File: rtl/key_input_port.sv
// Keyboard input port: buffers decoded key codes in a small FIFO and presents
// them, plus a status byte, on a registered processor input port with an interrupt handshake.
module key_input_port #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] key_code,
  input  logic       key_valid,
  input  logic [7:0] port_id,
  input  logic       read_strobe,
  input  logic       interrupt_ack,
  output logic [7:0] in_port,
  output logic       interrupt,
  output logic       overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    in_port_q, in_port_d;
  state_t        state_q, state_d;

  logic       empty, full;
  logic       push_req, push, pop;
  logic [4:0] count_ext;
  logic [2:0] count_sat;
  logic [7:0] status;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign push_req = key_valid && (key_code != 8'h00);
  assign pop      = read_strobe && (port_id == 8'h00) && !empty;
  // A pop frees the slot in the same cycle, so a push into a full FIFO is accepted then.
  assign push     = push_req && (!full || pop);

  assign count_ext = 5'(count_q);
  assign count_sat = (count_ext > 5'd7) ? 3'd7 : count_ext[2:0];
  assign status    = {overflow_q, count_sat, 2'b00, full, !empty};

  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    in_port_d  = 8'h00;

    if (push) begin
      mem_d[wr_ptr_q] = key_code;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Clear is applied first so a simultaneous new overflow wins.
    if (read_strobe && (port_id == 8'h01)) begin
      overflow_d = 1'b0;
    end
    if (push_req && full && !pop) begin
      overflow_d = 1'b1;
    end

    case (port_id)
      8'h00:   in_port_d = empty ? 8'h00 : mem_q[rd_ptr_q];
      8'h01:   in_port_d = status;
      default: in_port_d = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty) state_d = REQ;
      REQ:     if (interrupt_ack) state_d = SERVICE;
      SERVICE: if (empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      in_port_q  <= '0;
      state_q    <= IDLE;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      in_port_q  <= in_port_d;
      state_q    <= state_d;
    end
  end

  // Storage needs no reset: entries are only observable while counted as valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign in_port   = in_port_q;
  assign interrupt = (state_q == REQ);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_input_port.sv
// Self-checking bench for key_input_port: directed vector table plus randomized
// traffic checked against a queue-based reference model.
module tb_key_input_port;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       key_valid = 1'b0;
  logic [7:0] port_id = 8'h00;
  logic       read_strobe = 1'b0;
  logic       interrupt_ack = 1'b0;
  logic [7:0] in_port;
  logic       interrupt;
  logic       overflow;

  int checks = 0;
  int failures = 0;

  key_input_port #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .port_id      (port_id),
    .read_strobe  (read_strobe),
    .interrupt_ack(interrupt_ack),
    .in_port      (in_port),
    .interrupt    (interrupt),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       kv;
    logic [7:0] kc;
    logic [7:0] pid;
    logic       rs;
    logic       ack;
    logic       rstn;
    logic [7:0] e_in;
    logic       e_irq;
    logic       e_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic kv, logic [7:0] kc, logic [7:0] pid, logic rs,
                              logic ack, logic rstn, logic [7:0] e_in, logic e_irq,
                              logic e_ovf);
    vec_t v;
    v.kv = kv; v.kc = kc; v.pid = pid; v.rs = rs; v.ack = ack; v.rstn = rstn;
    v.e_in = e_in; v.e_irq = e_irq; v.e_ovf = e_ovf;
    tbl.push_back(v);
  endfunction

  // Reference model: a byte queue, a sticky flag and a three-phase handshake.
  localparam int M_IDLE = 0, M_REQ = 1, M_SERVICE = 2;
  byte unsigned mq[$];
  bit           m_ovf = 1'b0;
  int           m_mode = M_IDLE;
  logic [7:0]   m_in = 8'h00;

  task automatic model_edge(logic kv, logic [7:0] kc, logic [7:0] pid, logic rs,
                            logic ack, logic rstn);
    int n;
    bit do_pop, want, was_full;
    logic [7:0] s;
    if (!rstn) begin
      mq.delete();
      m_ovf = 1'b0;
      m_mode = M_IDLE;
      m_in = 8'h00;
      return;
    end
    n = mq.size();
    s = 8'h00;
    s[7]   = m_ovf;
    s[6:4] = (n > 7) ? 3'd7 : 3'(n);
    s[1]   = (n == DEPTH);
    s[0]   = (n != 0);
    if (pid == 8'h00) m_in = (n != 0) ? mq[0] : 8'h00;
    else if (pid == 8'h01) m_in = s;
    else m_in = 8'h00;
    do_pop   = rs && (pid == 8'h00) && (n > 0);
    want     = kv && (kc != 8'h00);
    was_full = (n == DEPTH);
    if (m_mode == M_IDLE && n > 0) m_mode = M_REQ;
    else if (m_mode == M_REQ && ack) m_mode = M_SERVICE;
    else if (m_mode == M_SERVICE && n == 0) m_mode = M_IDLE;
    if (do_pop) void'(mq.pop_front());
    if (want && (!was_full || do_pop)) mq.push_back(kc);
    m_ovf = (m_ovf && !(rs && pid == 8'h01)) || (want && was_full && !do_pop);
  endtask

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic apply(logic kv, logic [7:0] kc, logic [7:0] pid, logic rs,
                       logic ack, logic rstn);
    key_valid = kv; key_code = kc; port_id = pid;
    read_strobe = rs; interrupt_ack = ack; reset = rstn;
    @(posedge clk);
    model_edge(kv, kc, pid, rs, ack, rstn);
    #1;
  endtask

  initial begin
    //  kv  kc     pid    rs ack rstn  in     irq ovf
    add(0, 8'h00, 8'h00, 0, 0, 0,    8'h00, 0, 0);
    add(1, 8'h41, 8'h00, 1, 1, 0,    8'h00, 0, 0);   // reset beats all inputs
    add(1, 8'h57, 8'h00, 0, 0, 1,    8'h00, 0, 0);   // single key
    add(0, 8'h00, 8'h00, 0, 0, 1,    8'h57, 1, 0);
    add(0, 8'h00, 8'h00, 1, 0, 1,    8'h57, 1, 0);
    add(0, 8'h00, 8'h00, 0, 0, 1,    8'h00, 1, 0);
    add(0, 8'h00, 8'h01, 0, 0, 1,    8'h00, 1, 0);
    add(0, 8'h00, 8'h00, 0, 1, 1,    8'h00, 0, 0);
    add(0, 8'h00, 8'h00, 0, 0, 1,    8'h00, 0, 0);
    add(1, 8'h41, 8'h01, 0, 0, 1,    8'h00, 0, 0);   // overflow fill
    add(1, 8'h44, 8'h01, 0, 0, 1,    8'h11, 1, 0);
    add(1, 8'h57, 8'h01, 0, 0, 1,    8'h21, 1, 0);
    add(1, 8'h53, 8'h01, 0, 0, 1,    8'h31, 1, 0);
    add(1, 8'h49, 8'h01, 0, 0, 1,    8'h43, 1, 1);
    add(0, 8'h00, 8'h01, 1, 0, 1,    8'hC3, 1, 0);
    add(0, 8'h00, 8'h01, 0, 0, 1,    8'h43, 1, 0);
    add(1, 8'h50, 8'h00, 1, 0, 1,    8'h41, 1, 0);   // full push+pop
    add(0, 8'h00, 8'h01, 0, 0, 1,    8'h43, 1, 0);
    add(0, 8'h00, 8'h00, 1, 0, 1,    8'h44, 1, 0);
    add(0, 8'h00, 8'h00, 1, 0, 1,    8'h57, 1, 0);
    add(0, 8'h00, 8'h00, 1, 0, 1,    8'h53, 1, 0);
    add(0, 8'h00, 8'h00, 1, 0, 1,    8'h50, 1, 0);
    add(0, 8'h00, 8'h00, 0, 1, 1,    8'h00, 0, 0);
    add(0, 8'h00, 8'h00, 0, 0, 1,    8'h00, 0, 0);
    add(1, 8'h61, 8'h00, 0, 0, 1,    8'h00, 0, 0);   // handshake
    add(1, 8'h62, 8'h00, 0, 0, 1,    8'h61, 1, 0);
    add(0, 8'h00, 8'h00, 0, 1, 1,    8'h61, 0, 0);
    add(1, 8'h63, 8'h00, 0, 0, 1,    8'h61, 0, 0);
    add(0, 8'h00, 8'h00, 1, 0, 1,    8'h61, 0, 0);
    add(0, 8'h00, 8'h00, 1, 0, 1,    8'h62, 0, 0);
    add(0, 8'h00, 8'h00, 1, 0, 1,    8'h63, 0, 0);
    add(0, 8'h00, 8'h00, 0, 1, 1,    8'h00, 0, 0);
    add(1, 8'h08, 8'h00, 0, 0, 1,    8'h00, 0, 0);
    add(0, 8'h00, 8'h00, 0, 0, 1,    8'h08, 1, 0);
    add(1, 8'h09, 8'h00, 0, 0, 1,    8'h08, 1, 0);   // reset mid-operation
    add(1, 8'h0A, 8'h00, 0, 0, 1,    8'h08, 1, 0);
    add(1, 8'h0B, 8'h00, 1, 1, 0,    8'h00, 0, 0);
    add(0, 8'h00, 8'h01, 0, 0, 1,    8'h00, 0, 0);
    add(0, 8'h00, 8'h00, 0, 0, 1,    8'h00, 0, 0);
    add(1, 8'h00, 8'h00, 0, 0, 1,    8'h00, 0, 0);   // zero code filtered
    add(0, 8'h00, 8'h00, 0, 0, 1,    8'h00, 0, 0);
    add(1, 8'h71, 8'h05, 1, 0, 1,    8'h00, 0, 0);   // unmapped port
    add(0, 8'h00, 8'h05, 1, 0, 1,    8'h00, 1, 0);
    add(0, 8'h00, 8'h01, 0, 0, 1,    8'h11, 1, 0);
    add(0, 8'h00, 8'h00, 0, 0, 1,    8'h71, 1, 0);
    add(0, 8'h00, 8'h00, 0, 1, 1,    8'h71, 0, 0);   // re-raise after service
    add(0, 8'h00, 8'h00, 1, 0, 1,    8'h71, 0, 0);
    add(1, 8'h72, 8'h00, 0, 0, 1,    8'h00, 0, 0);
    add(0, 8'h00, 8'h00, 0, 0, 1,    8'h72, 1, 0);
    add(1, 8'h73, 8'h01, 0, 0, 1,    8'h11, 1, 0);   // set beats clear
    add(1, 8'h74, 8'h01, 0, 0, 1,    8'h21, 1, 0);
    add(1, 8'h75, 8'h01, 0, 0, 1,    8'h31, 1, 0);
    add(1, 8'h76, 8'h01, 1, 0, 1,    8'h43, 1, 1);
    add(0, 8'h00, 8'h01, 1, 0, 1,    8'hC3, 1, 0);
    add(0, 8'h00, 8'h01, 0, 0, 1,    8'h43, 1, 0);

    foreach (tbl[i]) begin
      apply(tbl[i].kv, tbl[i].kc, tbl[i].pid, tbl[i].rs, tbl[i].ack, tbl[i].rstn);
      check($sformatf("vec%0d_in_port", i), in_port, tbl[i].e_in);
      check($sformatf("vec%0d_interrupt", i), {7'd0, interrupt}, {7'd0, tbl[i].e_irq});
      check($sformatf("vec%0d_overflow", i), {7'd0, overflow}, {7'd0, tbl[i].e_ovf});
    end

    apply(0, 8'h00, 8'h00, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      logic       kv, rs, ack, rstn;
      logic [7:0] kc, pid;
      int         sel;
      kv   = ($urandom_range(0, 1) == 1);
      kc   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      sel  = $urandom_range(0, 4);
      pid  = (sel < 2) ? 8'h00 : (sel < 4) ? 8'h01 : 8'($urandom_range(0, 255));
      rs   = ($urandom_range(0, 9) < 4);
      ack  = ($urandom_range(0, 4) == 0);
      rstn = ($urandom_range(0, 99) != 0);
      apply(kv, kc, pid, rs, ack, rstn);
      check($sformatf("rnd%0d_in_port", c), in_port, m_in);
      check($sformatf("rnd%0d_interrupt", c), {7'd0, interrupt}, {7'd0, m_mode == M_REQ});
      check($sformatf("rnd%0d_overflow", c), {7'd0, overflow}, {7'd0, m_ovf});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
